// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline types, widths and address helpers.
package mips_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W = 5;
    localparam logic [WORD_W-1:0] BASE_ADDR_DEF = 32'd1024;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    function automatic logic [WORD_W-1:0] phys_addr(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] base);
        return (a - base) & ~32'd3;
    endfunction
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: 8-bit access watchdog; hit flags the cycle whose stall reaches LIMIT.
module mem_timeout_cnt #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    // count including this cycle's stall equals LIMIT
    assign hit = en && (cnt_q == LIMIT - 8'd1);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; one word access per memory op over a req/ready
// handshake, freezing upstream stages while outstanding.
import mips_pkg::*;
module mem_stage #(
    parameter logic [WORD_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [WORD_W-1:0] ALU_result_in,
    input  logic [WORD_W-1:0] Val_Rt_in,
    input  logic [REG_W-1:0]  Dest_in,
    input  logic [WORD_W-1:0] PC_in,
    output logic              valid_out,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [WORD_W-1:0] ALU_result,
    output logic [REG_W-1:0]  Dest,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] Mem_read_value,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);
    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d;
    logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic              mem_op, start, in_acc, cnt_en, hit;

    assign mem_op = valid_in && (MEM_R_EN_in || MEM_W_EN_in);
    assign start  = (state_q == IDLE) && mem_op;
    assign in_acc = (state_q == ACCESS);
    assign cnt_en = in_acc && !mem_ready;

    mem_timeout_cnt #(.LIMIT(8'(TIMEOUT))) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(start),
        .en (cnt_en),
        .hit(hit)
    );

    always_comb begin
        state_d = start ? ACCESS
                : (in_acc && (mem_ready || hit)) ? DONE
                : (state_q == DONE) ? IDLE
                : state_q;
        req_d   = (state_d == ACCESS);
        we_d    = start ? MEM_W_EN_in : we_q;
        addr_d  = start ? phys_addr(ALU_result_in, BASE_ADDR) : addr_q;
        wdata_d = start ? Val_Rt_in : wdata_q;
        // a dual-enable op is a store whose read value must read back as zero
        rdata_d = ((start && MEM_R_EN_in && MEM_W_EN_in) || hit) ? '0
                : (in_acc && mem_ready && !we_q) ? mem_rdata
                : rdata_q;
        err_d   = err_q || hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign freeze         = start || in_acc;
    assign valid_out      = valid_in && !freeze;
    assign WB_en          = WB_en_in;
    assign MEM_R_EN       = MEM_R_EN_in;
    assign ALU_result     = ALU_result_in;
    assign Dest           = Dest_in;
    assign PC             = PC_in;
    assign Mem_read_value = rdata_q;
    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_err        = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model.
module tb_mem_stage;
    localparam int TO = 255;
    logic        clk = 1'b0, rst = 1'b0;
    logic        valid_in = 0, WB_en_in = 0, MEM_R_EN_in = 0, MEM_W_EN_in = 0;
    logic [31:0] ALU_result_in = 0, Val_Rt_in = 0, PC_in = 0, mem_rdata = 0;
    logic [4:0]  Dest_in = 0;
    logic        mem_ready = 0;
    logic        valid_out, WB_en, MEM_R_EN, freeze, mem_req, mem_we, mem_err;
    logic [31:0] ALU_result, PC, Mem_read_value, mem_addr, mem_wdata;
    logic [4:0]  Dest;
    int          passed = 0, total = 0;
    logic [31:0] exp_rv = 0;
    logic        exp_err = 0;

    mem_stage #(.BASE_ADDR(32'd1024), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .WB_en_in(WB_en_in),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .Val_Rt_in(Val_Rt_in), .Dest_in(Dest_in), .PC_in(PC_in),
        .valid_out(valid_out), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .Dest(Dest), .PC(PC), .Mem_read_value(Mem_read_value), .freeze(freeze),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nonmem(input logic [31:0] alu);
        valid_in = 1; WB_en_in = 1; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_result_in = alu; Dest_in = 5'($urandom); PC_in = $urandom; mem_ready = 1;
        @(negedge clk);
        chk("nm_valid_out", 32'(valid_out), 32'd1);
        chk("nm_freeze", 32'(freeze), 32'd0);
        chk("nm_alu", ALU_result, alu);
        chk("nm_wb", 32'(WB_en), 32'd1);
        chk("nm_req", 32'(mem_req), 32'd0);
        step();
        mem_ready = 0;
    endtask

    // k = cycle of ACCESS in which the memory answers; 0 means never
    task automatic mem_op(input logic r, input logic w, input logic [31:0] alu,
                          input logic [31:0] rt, input logic [31:0] rd, input int k);
        logic        tmo = (k == 0) || (k > TO);
        int          n_acc = tmo ? TO : k;
        logic [31:0] ea = (alu - 32'd1024) & ~32'd3;
        logic [31:0] pc = $urandom;
        logic [4:0]  dst = 5'($urandom);
        valid_in = 1; WB_en_in = r; MEM_R_EN_in = r; MEM_W_EN_in = w;
        ALU_result_in = alu; Val_Rt_in = rt; Dest_in = dst; PC_in = pc; mem_ready = 0;
        @(negedge clk);
        chk("idle_freeze", 32'(freeze), 32'd1);
        chk("idle_valid_out", 32'(valid_out), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        step();
        for (int n = 1; n <= n_acc; n++) begin
            mem_ready = (n == k);
            mem_rdata = (n == k) ? rd : $urandom;
            @(negedge clk);
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_freeze", 32'(freeze), 32'd1);
            chk("acc_valid_out", 32'(valid_out), 32'd0);
            chk("acc_addr", mem_addr, ea);
            chk("acc_we", 32'(mem_we), 32'(w));
            chk("acc_wdata", mem_wdata, rt);
            step();
        end
        mem_ready = 0;
        if (tmo) begin
            exp_rv = 0;
            exp_err = 1;
        end else if (r && w) exp_rv = 0;
        else if (r) exp_rv = rd;
        @(negedge clk);
        chk("done_freeze", 32'(freeze), 32'd0);
        chk("done_valid_out", 32'(valid_out), 32'd1);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_rdval", Mem_read_value, exp_rv);
        chk("done_err", 32'(mem_err), 32'(exp_err));
        chk("done_alu", ALU_result, alu);
        chk("done_dest", 32'(Dest), 32'(dst));
        chk("done_pc", PC, pc);
        step();
    endtask

    initial begin
        step();
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdval", Mem_read_value, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        step();
        rst = 1;
        step();
        nonmem(32'h55);
        mem_op(1, 0, 32'd1028, 32'h0, 32'hCAFE0001, 1);
        mem_op(0, 1, 32'd1033, 32'h12345678, 32'hDEADBEEF, 4);
        mem_op(1, 1, 32'd1040, 32'hA5A5A5A5, 32'h77777777, 2);
        for (int i = 0; i < 24; i++) begin
            int sel = $urandom_range(0, 3);
            if (sel == 0) nonmem($urandom);
            else mem_op(sel != 2, sel != 1, 32'd1024 + $urandom_range(0, 4095), $urandom, $urandom,
                        $urandom_range(1, 8));
        end
        mem_op(1, 0, 32'd1100, 32'h0, 32'h0BADF00D, TO);
        mem_op(1, 0, 32'd1200, 32'h0, 32'h11111111, 0);
        mem_op(1, 0, 32'd1204, 32'h0, 32'h22222222, 3);
        valid_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; ALU_result_in = 32'd2048;
        step();
        step();
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst = 0;
        valid_in = 0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_rdval", Mem_read_value, 32'd0);
        chk("arst_err", 32'(mem_err), 32'd0);
        chk("arst_freeze", 32'(freeze), 32'd0);
        exp_rv = 0;
        exp_err = 0;
        step();
        rst = 1;
        step();
        mem_op(1, 0, 32'd1060, 32'h0, 32'h5EED5EED, 2);
        valid_in = 0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS pipeline. It sits between the EXE stage register and `MEM_Stage_reg`. It issues one word-wide load or store per memory instruction to an external data memory over a request/ready handshake, and freezes upstream stages while the access is outstanding. When the access completes, it presents the instruction's write-back fields and load data to `MEM_Stage_reg`.

## Interface
Parameters:
- `BASE_ADDR`, 1024: subtracted from `ALU_result_in` to form the physical memory address.
- `TIMEOUT`, 255: maximum number of cycles spent in ACCESS before the access is aborted.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_in` in 1: the EXE register holds a live instruction.
- `WB_en_in`, `MEM_R_EN_in`, `MEM_W_EN_in` in 1 each: control bits from EXE.
- `ALU_result_in` in 32: effective address, or the ALU result for non-memory instructions.
- `Val_Rt_in` in 32: store data.
- `Dest_in` in 5: destination register.
- `PC_in` in 32: instruction PC.
- `valid_out` out 1: outputs are final this cycle; `MEM_Stage_reg` may capture them.
- `WB_en`, `MEM_R_EN` out 1 each: passed through to `MEM_Stage_reg`.
- `ALU_result` out 32, `Dest` out 5, `PC` out 32: passed through to `MEM_Stage_reg`.
- `Mem_read_value` out 32: registered load data.
- `freeze` out 1: stalls PC, IF, ID and EXE registers.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: data memory request.
- `mem_rdata` in 32, `mem_ready` in 1: data memory response.
- `mem_err` out 1: sticky timeout flag.

## Operation
- The state machine has three states: IDLE, ACCESS and DONE. Reset state is IDLE.
- A memory op is `valid_in && (MEM_R_EN_in || MEM_W_EN_in)`.
  - If both enables are set, the op is a store and `Mem_read_value` is 0.
- IDLE:
  - Memory op present: go to ACCESS and load the request registers.
  - Otherwise stay in IDLE; a non-memory instruction passes straight through.
- ACCESS:
  - `mem_req`=1. `mem_addr = (ALU_result_in - BASE_ADDR) & ~3`, `mem_we`, and `mem_wdata = Val_Rt_in` are registered and held stable.
  - On `mem_ready`=1 for a load, capture `mem_rdata` into `rdata_q`.
  - On `mem_ready`=1 for a store, leave `rdata_q` unchanged. Go to DONE.
  - On timeout (see below), set `mem_err`, write 0 to `rdata_q`, and go to DONE.
- DONE: `mem_req`=0 for one cycle, then go to IDLE.
- Combinational outputs:
  - `freeze = (IDLE && memory op) || ACCESS`.
  - `valid_out = valid_in && !freeze`.
  - Pass-through outputs are combinational copies of the inputs. The EXE register is frozen, so they stay stable.
  - `Mem_read_value` equals `rdata_q`.
- Timeout counter:
  - 8-bit counter, cleared on entry to ACCESS, increments each ACCESS cycle without `mem_ready`.
  - The access aborts when the count equals `TIMEOUT`, provided `mem_ready` is low that cycle.
  - `mem_ready` in the same cycle as the limit counts as success.
- `mem_err` stays set until reset.
- `mem_ready` outside ACCESS is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we` 0.
  - `mem_addr`, `mem_wdata`, `rdata_q` 0, hence `Mem_read_value` 0.
  - Counter 0, `mem_err` 0.
  - `freeze` 0 when `valid_in` is 0.
- Non-memory instruction: zero added latency, `valid_out` in the same cycle.
- Memory op with a memory that answers in k cycles (k ≥ 1):
  - Cycle 0: IDLE, `freeze`=1.
  - Cycles 1..k: ACCESS, with `mem_ready` in cycle k.
  - Cycle k+1: DONE, `freeze`=0, `valid_out`=1.
  - Minimum total is 3 cycles.
- Back-to-back memory ops: the second op's IDLE cycle immediately follows DONE.
- Reset mid-access:
  - `mem_req` drops asynchronously and the transaction is abandoned; the memory must tolerate this.
  - `freeze` then reflects IDLE.

## Structure
- Shared package `mips_pkg`:
  - State enum (IDLE/ACCESS/DONE).
  - `BASE_ADDR` default.
  - Word/register-index width constants.
- Optional sub-module `mem_timeout_cnt`: counter with clear/enable/limit-hit outputs. Everything else stays in `mem_stage`.

## Test plan
- `valid_in`=1, `WB_en_in`=1, `ALU_result_in`=32'h55, no mem enables -> `valid_out`=1 the same cycle, `freeze`=0, `ALU_result`=32'h55.
- Load at `ALU_result_in`=1028, `mem_ready` 1 cycle after `mem_req` rises, `mem_rdata`=32'hCAFE0001 -> `mem_addr`=4, `freeze` high 2 cycles, `valid_out` in cycle 2, `Mem_read_value`=32'hCAFE0001.
- Store of 32'h12345678 at 1033, `mem_ready` on the 4th ACCESS cycle:
  - `mem_we`=1, `mem_addr`=8, `mem_wdata` stable throughout.
  - `freeze` high 5 cycles.
  - `Mem_read_value` unchanged.
- Load with `mem_ready` never asserted, `TIMEOUT`=255 -> abort after 255 ACCESS cycles, `mem_err`=1 (sticky), `Mem_read_value`=0, `valid_out` pulse.
- `rst` low during ACCESS -> `mem_req`=0 immediately, state IDLE, all reset values. After release, a fresh load completes normally.
- Both `MEM_R_EN_in` and `MEM_W_EN_in` set -> store performed, `Mem_read_value`=0.
